// File: rtl/vic_pot_sampler.sv
// vic_pot_sampler: emulates the VIC paddle (POT) sampling cycle.
// A discharge phase of DISCH_LEN ce ticks is followed by a 256-tick charge
// phase in which each pot's comparator trips once the charge count reaches
// the paddle value snapshotted at the end of discharge. A one-clk update
// state then publishes the captured samples on pot_x/pot_y.
// Optional feature macro: POT_FILTER_EN (averages each new sample with the
// previous published value instead of publishing it directly).
//
// Handshake: there is none; ce is a plain tick enable and pot_update is a
// single-clk strobe that coincides with the first clk on which pot_x/pot_y
// carry the refreshed values.
module vic_pot_sampler #(
    parameter int DISCH_LEN = 256
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ce,
    input  logic [7:0] pd_x,
    input  logic [7:0] pd_y,
    input  logic [1:0] pd_valid,
    output logic [7:0] pot_x,
    output logic [7:0] pot_y,
    output logic [1:0] pot_line,
    output logic       pot_update,
    output logic [1:0] state_dbg
);

    typedef enum logic [1:0] {
        S_DISCH  = 2'd0,
        S_CHARGE = 2'd1,
        S_UPDATE = 2'd2
    } state_t;

    localparam logic [9:0] DISCH_LAST  = 10'(DISCH_LEN - 1);
    localparam logic [9:0] CHARGE_LAST = 10'd255;

    state_t     state_q, state_d;
    logic [9:0] cnt_q, cnt_d;
    logic [7:0] thr_x_q, thr_x_d;
    logic [7:0] thr_y_q, thr_y_d;
    logic [7:0] samp_x_q, samp_x_d;
    logic [7:0] samp_y_q, samp_y_d;
    logic [1:0] done_q, done_d;
    logic [1:0] line_q, line_d;
    logic [7:0] pot_x_q, pot_x_d;
    logic [7:0] pot_y_q, pot_y_d;
    logic       upd_q, upd_d;

    // Next-state, counter, snapshot, capture and publish logic.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        thr_x_d  = thr_x_q;
        thr_y_d  = thr_y_q;
        samp_x_d = samp_x_q;
        samp_y_d = samp_y_q;
        done_d   = done_q;
        line_d   = line_q;
        pot_x_d  = pot_x_q;
        pot_y_d  = pot_y_q;
        upd_d    = 1'b0;
        case (state_q)
            S_DISCH: begin
                line_d = 2'b00;
                if (ce) begin
                    if (cnt_q == DISCH_LAST) begin
                        state_d = S_CHARGE;
                        cnt_d   = 10'd0;
                        // An unassigned paddle floats: it never trips early.
                        thr_x_d = pd_valid[0] ? pd_x : 8'hFF;
                        thr_y_d = pd_valid[1] ? pd_y : 8'hFF;
                    end else begin
                        cnt_d = cnt_q + 10'd1;
                    end
                end
            end
            S_CHARGE: begin
                if (ce) begin
                    if (!done_q[0] && (cnt_q[7:0] >= thr_x_q)) begin
                        samp_x_d  = cnt_q[7:0];
                        done_d[0] = 1'b1;
                        line_d[0] = 1'b1;
                    end
                    if (!done_q[1] && (cnt_q[7:0] >= thr_y_q)) begin
                        samp_y_d  = cnt_q[7:0];
                        done_d[1] = 1'b1;
                        line_d[1] = 1'b1;
                    end
                    if (cnt_q == CHARGE_LAST) begin
                        // Channels still charging saturate at full scale.
                        if (!done_d[0]) begin
                            samp_x_d  = 8'hFF;
                            done_d[0] = 1'b1;
                            line_d[0] = 1'b1;
                        end
                        if (!done_d[1]) begin
                            samp_y_d  = 8'hFF;
                            done_d[1] = 1'b1;
                            line_d[1] = 1'b1;
                        end
                        state_d = S_UPDATE;
                        cnt_d   = 10'd0;
                    end else begin
                        cnt_d = cnt_q + 10'd1;
                    end
                end
            end
            S_UPDATE: begin
`ifdef POT_FILTER_EN
                pot_x_d = 8'((9'(pot_x_q) + 9'(samp_x_q) + 9'd1) >> 1);
                pot_y_d = 8'((9'(pot_y_q) + 9'(samp_y_q) + 9'd1) >> 1);
`else
                pot_x_d = samp_x_q;
                pot_y_d = samp_y_q;
`endif
                upd_d   = 1'b1;
                state_d = S_DISCH;
                cnt_d   = 10'd0;
                done_d  = 2'b00;
                line_d  = 2'b00;
            end
            default: begin
                state_d = S_DISCH;
                cnt_d   = 10'd0;
                done_d  = 2'b00;
                line_d  = 2'b00;
            end
        endcase
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_DISCH;
            cnt_q    <= 10'd0;
            thr_x_q  <= 8'hFF;
            thr_y_q  <= 8'hFF;
            samp_x_q <= 8'hFF;
            samp_y_q <= 8'hFF;
            done_q   <= 2'b00;
            line_q   <= 2'b00;
            pot_x_q  <= 8'hFF;
            pot_y_q  <= 8'hFF;
            upd_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            thr_x_q  <= thr_x_d;
            thr_y_q  <= thr_y_d;
            samp_x_q <= samp_x_d;
            samp_y_q <= samp_y_d;
            done_q   <= done_d;
            line_q   <= line_d;
            pot_x_q  <= pot_x_d;
            pot_y_q  <= pot_y_d;
            upd_q    <= upd_d;
        end
    end

    assign pot_x      = pot_x_q;
    assign pot_y      = pot_y_q;
    assign pot_line   = line_q;
    assign pot_update = upd_q;
    assign state_dbg  = state_q;

endmodule

// File: doc/vic_pot_sampler.md
VIC_POT_SAMPLER -- requirements
Module: vic_pot_sampler

Interface
REQ-001 Parameter DISCH_LEN, default 256, sets the discharge phase length in ce ticks (legal 2..1024).
REQ-002 clk  input  1  system clock; all state SHALL change only on its rising edge, except under reset.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 ce  input  1  sampling tick enable (phi2 rate); FSM and counter SHALL advance only when ce=1, except in S_UPDATE.
REQ-005 pd_x  input  8  paddle value for POTX, from the paddle chooser pd_out.
REQ-006 pd_y  input  8  paddle value for POTY.
REQ-007 pd_valid  input  2  bit0 = POTX source assigned, bit1 = POTY source assigned.
REQ-008 pot_x  output  8  latched POTX register value.
REQ-009 pot_y  output  8  latched POTY register value.
REQ-010 pot_line  output  2  emulated comparator state per pot: 1 = capacitor charged past threshold.
REQ-011 pot_update  output  1  single-clk pulse when pot_x/pot_y are refreshed.

Function
REQ-012 FSM states SHALL be S_DISCH, S_CHARGE and S_UPDATE, with an 10-bit tick counter cnt.
REQ-013 S_DISCH: on each ce, cnt increments; pot_line SHALL be 2'b00.
REQ-014 S_DISCH: on the ce where cnt = DISCH_LEN-1, the FSM SHALL go to S_CHARGE, clear cnt, and snapshot pd_x, pd_y and pd_valid.
REQ-015 Snapshot rule: a channel whose snapshot valid bit is 0 SHALL use threshold 8'hFF (floating pot).
REQ-016 Input changes after the snapshot SHALL have no effect until the next cycle.
REQ-017 S_CHARGE: on each ce, if cnt[7:0] >= a channel threshold and that channel is not done, the block SHALL latch cnt[7:0] into the channel sample, set done, and set the pot_line bit.
REQ-018 S_CHARGE: cnt increments per ce; on the ce where cnt = 255, any channel not yet done SHALL latch 8'hFF, and the FSM SHALL go to S_UPDATE.
REQ-019 A threshold of 0 SHALL latch 0 on the first charge tick.
REQ-020 Both channels reaching threshold on the same tick SHALL both latch on that tick.
REQ-021 S_UPDATE: lasts exactly one clk regardless of ce; pot_x/pot_y SHALL be written per REQ-027; pot_update=1 for that clk; next state is S_DISCH with cnt=0 and done flags cleared.
REQ-022 Latency: snapshot to pot_update SHALL be exactly 256 ce ticks plus 1 clk.
REQ-023 Full period SHALL be DISCH_LEN+256 ce ticks plus 1 clk.
REQ-024 ce=0 SHALL freeze cnt, state (except S_UPDATE), samples and pot_line.

Reset
REQ-025 While reset=1: state=S_DISCH, cnt=0, done=0, samples=8'hFF, pot_x=pot_y=8'hFF, pot_line=2'b00, pot_update=0, filter history=8'hFF.
REQ-026 Reset asserted mid-cycle SHALL abort the cycle with no pot_update; after release, the first update SHALL occur DISCH_LEN+256 ce ticks later.

Configuration
REQ-027 Macro POT_FILTER_EN defined: pot_x = (prev_pot_x + sample_x + 1) >> 1 using a 9-bit sum, likewise for pot_y; undefined: pot_x = sample_x and pot_y = sample_y directly, with no history registers.

Verification
REQ-028 Reset release, ce=1 continuously, pd_x=8'h40, pd_y=8'hC0, pd_valid=2'b11, no filter -> first pot_update 513 clks after release (DISCH_LEN=256); pot_x=8'h40, pot_y=8'hC0; pot_line[0] rises 65 ce ticks into S_CHARGE.
REQ-029 pd_valid=2'b01, pd_y=8'h10 -> pot_y=8'hFF; pot_line[1] rises only on the final charge tick.
REQ-030 pd_x=8'h00, pd_y=8'hFF -> pot_x=0 latched on the first charge tick; pot_y=8'hFF; both captured in the same update.
REQ-031 ce asserted every 4th clk, pd_x changed from 8'h20 to 8'h80 mid-S_CHARGE -> that update gives pot_x=8'h20; the next update gives 8'h80; the update period is 4*(DISCH_LEN+256) clks plus at most 1 clk.
REQ-032 POT_FILTER_EN defined, pot_x history 8'hFF, pd_x=8'h00 held -> successive pot_x values 8'h80, 8'h40, 8'h20.
REQ-033 reset pulsed 100 ce ticks into S_CHARGE -> no pot_update during or after the pulse until a full DISCH_LEN+256 ticks; outputs equal 8'hFF meanwhile.
